pc_next_unit: RTL and testbench

PC_NEXT_UNIT -- requirements
Module: pc_next_unit

---
 rtl/pc_next_unit.sv | 126 ++++++++++++
 tb/tb_pc_next_unit.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_next_unit.sv
// rtl/pc_next_unit.sv - next-PC selection with exception redirect and return-address stack
module pc_next_unit #(
    parameter int                 WIDTH      = 32,
    parameter logic [WIDTH-1:0]   RESET_PC   = 32'h0000_0000,
    parameter logic [WIDTH-1:0]   EXC_VECTOR = 32'h8000_0180,
    parameter int                 RAS_DEPTH  = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             branch,
    input  logic [WIDTH-1:0] signimm,
    input  logic             jump,
    input  logic [25:0]      jaddr,
    input  logic             jr,
    input  logic [WIDTH-1:0] jr_target,
    input  logic             link,
    input  logic             ret,
    input  logic             exc,
    input  logic             eret,
    output logic [WIDTH-1:0] pc,
    output logic [WIDTH-1:0] pc_plus4,
    output logic [WIDTH-1:0] pc_branch,
    output logic [WIDTH-1:0] epc,
    output logic [WIDTH-1:0] badaddr,
    output logic [WIDTH-1:0] ras_top,
    output logic             fault,
    output logic             ras_hit,
    output logic             ras_empty,
    output logic             ras_full
);

    localparam int             PW       = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam int             CW       = $clog2(RAS_DEPTH + 1);
    localparam logic [PW-1:0]  PTR_LAST = PW'(RAS_DEPTH - 1);
    localparam logic [CW-1:0]  CNT_FULL = CW'(RAS_DEPTH);

    // Circular return-address stack; ptr always indexes the current top entry.
    logic [WIDTH-1:0] ras_mem [RAS_DEPTH];
    logic [PW-1:0]    ptr;
    logic [CW-1:0]    count;

    logic [WIDTH-1:0] jump_target;
    logic [WIDTH-1:0] pc_next;
    logic [PW-1:0]    ptr_inc;
    logic [PW-1:0]    ptr_dec;
    logic             misaligned;
    logic             ras_en;
    logic             do_push;
    logic             do_pop;

    assign pc_plus4    = pc + WIDTH'(4);
    assign pc_branch   = pc_plus4 + (signimm << 2);
    assign jump_target = {pc_plus4[WIDTH-1:28], jaddr, 2'b00};

    assign ras_empty = (count == '0);
    assign ras_full  = (count == CNT_FULL);
    assign ras_top   = ras_empty ? '0 : ras_mem[ptr];

    // A misaligned jr becomes a fault unless a real exception already wins.
    assign misaligned = jr & (jr_target[1:0] != 2'b00) & ~exc;
    assign ras_en     = ~stall & ~exc & ~misaligned;
    assign do_push    = ras_en & link & (jump | jr);
    assign do_pop     = ras_en & jr & ret & ~ras_empty;

    assign ptr_inc = (ptr == PTR_LAST) ? '0 : ptr + PW'(1);
    assign ptr_dec = (ptr == '0) ? PTR_LAST : ptr - PW'(1);

    // Architectural next PC for an unstalled, non-trapping cycle; the RAS never steers it.
    always_comb begin
        pc_next = pc_plus4;
        if (eret) begin
            pc_next = epc;
        end else if (jr) begin
            pc_next = jr_target;
        end else if (jump) begin
            pc_next = jump_target;
        end else if (branch) begin
            pc_next = pc_branch;
        end
    end

    // PC, trap state, registered pulses and RAS updates in one clocked block.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc      <= RESET_PC;
            epc     <= '0;
            badaddr <= '0;
            fault   <= 1'b0;
            ras_hit <= 1'b0;
            ptr     <= '0;
            count   <= '0;
            for (int i = 0; i < RAS_DEPTH; i++) begin
                ras_mem[i] <= '0;
            end
        end else begin
            fault   <= 1'b0;
            ras_hit <= 1'b0;
            if (exc) begin
                pc  <= EXC_VECTOR;
                epc <= pc;
            end else if (misaligned) begin
                pc      <= EXC_VECTOR;
                epc     <= pc;
                badaddr <= jr_target;
                fault   <= 1'b1;
            end else if (!stall) begin
                pc      <= pc_next;
                ras_hit <= jr & ret & ~ras_empty & (ras_top == jr_target);
                if (do_push && do_pop) begin
                    ras_mem[ptr] <= pc_plus4;
                end else if (do_push) begin
                    ras_mem[ptr_inc] <= pc_plus4;
                    ptr              <= ptr_inc;
                    if (!ras_full) begin
                        count <= count + CW'(1);
                    end
                end else if (do_pop) begin
                    ptr   <= ptr_dec;
                    count <= count - CW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_pc_next_unit.sv
// tb/tb_pc_next_unit.sv - self-checking bench for pc_next_unit
module tb_pc_next_unit;

    localparam logic [31:0] RESET_PC   = 32'h0000_0000;
    localparam logic [31:0] EXC_VECTOR = 32'h8000_0180;
    localparam int          DEPTH      = 4;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        branch;
    logic [31:0] signimm;
    logic        jump;
    logic [25:0] jaddr;
    logic        jr;
    logic [31:0] jr_target;
    logic        link;
    logic        ret;
    logic        exc;
    logic        eret;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [31:0] pc_branch;
    logic [31:0] epc;
    logic [31:0] badaddr;
    logic [31:0] ras_top;
    logic        fault;
    logic        ras_hit;
    logic        ras_empty;
    logic        ras_full;

    int vectors;
    int miscompares;

    // Reference state: the RAS is a plain queue, newest entry at the back.
    logic [31:0] m_pc;
    logic [31:0] m_epc;
    logic [31:0] m_bad;
    logic        m_fault;
    logic        m_hit;
    logic [31:0] m_ras[$];

    pc_next_unit #(
        .WIDTH(32),
        .RESET_PC(RESET_PC),
        .EXC_VECTOR(EXC_VECTOR),
        .RAS_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rst(rst), .stall(stall), .branch(branch), .signimm(signimm),
        .jump(jump), .jaddr(jaddr), .jr(jr), .jr_target(jr_target), .link(link),
        .ret(ret), .exc(exc), .eret(eret), .pc(pc), .pc_plus4(pc_plus4),
        .pc_branch(pc_branch), .epc(epc), .badaddr(badaddr), .ras_top(ras_top),
        .fault(fault), .ras_hit(ras_hit), .ras_empty(ras_empty), .ras_full(ras_full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_step();
        logic [31:0] p4;
        logic [31:0] pb;
        logic [31:0] jt;
        bit          push;
        bit          pop;
        if (rst) begin
            m_pc = RESET_PC; m_epc = 0; m_bad = 0; m_fault = 0; m_hit = 0;
            m_ras.delete();
            return;
        end
        p4 = m_pc + 32'd4;
        pb = p4 + (signimm << 2);
        jt = {p4[31:28], jaddr, 2'b00};
        m_fault = 0;
        m_hit   = 0;
        if (exc) begin
            m_epc = m_pc;
            m_pc  = EXC_VECTOR;
        end else if (jr && jr_target[1:0] != 2'b00) begin
            m_epc   = m_pc;
            m_pc    = EXC_VECTOR;
            m_bad   = jr_target;
            m_fault = 1;
        end else if (!stall) begin
            m_hit = jr && ret && m_ras.size() > 0 && m_ras[$] == jr_target;
            push  = link && (jump || jr);
            pop   = jr && ret && m_ras.size() > 0;
            if (push && pop) begin
                m_ras[m_ras.size() - 1] = p4;
            end else if (push) begin
                m_ras.push_back(p4);
                if (m_ras.size() > DEPTH) void'(m_ras.pop_front());
            end else if (pop) begin
                void'(m_ras.pop_back());
            end
            if (eret)        m_pc = m_epc;
            else if (jr)     m_pc = jr_target;
            else if (jump)   m_pc = jt;
            else if (branch) m_pc = pb;
            else             m_pc = p4;
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rst = 0; stall = 0; branch = 0; signimm = 0; jump = 0; jaddr = 0;
        jr = 0; jr_target = 0; link = 0; ret = 0; exc = 0; eret = 0;
    endtask

    task automatic do_reset();
        idle();
        rst = 1;
        tick();
        rst = 0;
    endtask

    task automatic goto(input logic [31:0] addr);
        idle();
        jr = 1; jr_target = addr;
        tick();
        idle();
    endtask

    task automatic jal();
        idle();
        link = 1; jump = 1; jaddr = 26'h3;
        tick();
        idle();
    endtask

    task automatic test_reset();
        idle();
        rst = 1; stall = 1; jump = 1; jaddr = 26'h1234; exc = 1; link = 1;
        tick();
        tick();
        idle();
        vectors++; if (pc !== RESET_PC) begin miscompares++; $display("FAIL reset_pc: got %h expected %h", pc, RESET_PC); end
        vectors++; if (epc !== 32'h0) begin miscompares++; $display("FAIL reset_epc: got %h expected %h", epc, 32'h0); end
        vectors++; if (badaddr !== 32'h0) begin miscompares++; $display("FAIL reset_badaddr: got %h expected %h", badaddr, 32'h0); end
        vectors++; if ({fault, ras_hit, ras_empty, ras_full} !== 4'b0010) begin miscompares++; $display("FAIL reset_flags: got %b expected %b", {fault, ras_hit, ras_empty, ras_full}, 4'b0010); end
        vectors++; if (ras_top !== 32'h0) begin miscompares++; $display("FAIL reset_ras_top: got %h expected %h", ras_top, 32'h0); end
    endtask

    task automatic test_seq_branch();
        do_reset();
        vectors++; if (pc !== 32'h0) begin miscompares++; $display("FAIL seq_pc0: got %h expected %h", pc, 32'h0); end
        tick();
        vectors++; if (pc !== 32'h4) begin miscompares++; $display("FAIL seq_pc1: got %h expected %h", pc, 32'h4); end
        tick();
        vectors++; if (pc !== 32'h8) begin miscompares++; $display("FAIL seq_pc2: got %h expected %h", pc, 32'h8); end
        branch = 1; signimm = -32'sd2;
        #1;
        vectors++; if (pc_branch !== 32'h4) begin miscompares++; $display("FAIL branch_target: got %h expected %h", pc_branch, 32'h4); end
        tick();
        idle();
        vectors++; if (pc !== 32'h4) begin miscompares++; $display("FAIL branch_pc: got %h expected %h", pc, 32'h4); end
    endtask

    task automatic test_jump_stall();
        goto(32'h0040_0010);
        jump = 1; jaddr = 26'h010_0000; stall = 1;
        for (int i = 0; i < 2; i++) begin
            tick();
            vectors++; if (pc !== 32'h0040_0010) begin miscompares++; $display("FAIL stall_hold_%0d: got %h expected %h", i, pc, 32'h0040_0010); end
        end
        stall = 0;
        tick();
        idle();
        vectors++; if (pc !== 32'h0040_0000) begin miscompares++; $display("FAIL jump_pc: got %h expected %h", pc, 32'h0040_0000); end
    endtask

    task automatic test_ras_overflow();
        logic [31:0] exp_ret [4];
        exp_ret[0] = 32'h504; exp_ret[1] = 32'h404; exp_ret[2] = 32'h304; exp_ret[3] = 32'h204;
        do_reset();
        for (int k = 1; k <= 5; k++) begin
            goto(32'(k) * 32'h100);
            jal();
            if (k == 3) begin
                vectors++; if (ras_full !== 1'b0) begin miscompares++; $display("FAIL ras_full_3: got %b expected %b", ras_full, 1'b0); end
            end
            if (k == 4) begin
                vectors++; if (ras_full !== 1'b1) begin miscompares++; $display("FAIL ras_full_4: got %b expected %b", ras_full, 1'b1); end
            end
        end
        vectors++; if (ras_top !== 32'h504) begin miscompares++; $display("FAIL ras_top_5: got %h expected %h", ras_top, 32'h504); end
        vectors++; if (ras_full !== 1'b1) begin miscompares++; $display("FAIL ras_full_5: got %b expected %b", ras_full, 1'b1); end
        for (int r = 0; r < 4; r++) begin
            jr = 1; ret = 1; jr_target = exp_ret[r];
            tick();
            idle();
            vectors++; if (ras_hit !== 1'b1) begin miscompares++; $display("FAIL ret_hit_%0d: got %b expected %b", r, ras_hit, 1'b1); end
        end
        vectors++; if (ras_empty !== 1'b1) begin miscompares++; $display("FAIL ret5_empty: got %b expected %b", ras_empty, 1'b1); end
        jr = 1; ret = 1; jr_target = 32'h104;
        tick();
        idle();
        vectors++; if (ras_hit !== 1'b0) begin miscompares++; $display("FAIL ret5_hit: got %b expected %b", ras_hit, 1'b0); end
    endtask

    task automatic test_misaligned();
        do_reset();
        goto(32'h100);
        jal();
        goto(32'h40);
        jr = 1; ret = 1; jr_target = 32'h1002;
        tick();
        idle();
        vectors++; if (pc !== EXC_VECTOR) begin miscompares++; $display("FAIL mis_pc: got %h expected %h", pc, EXC_VECTOR); end
        vectors++; if (epc !== 32'h40) begin miscompares++; $display("FAIL mis_epc: got %h expected %h", epc, 32'h40); end
        vectors++; if (badaddr !== 32'h1002) begin miscompares++; $display("FAIL mis_badaddr: got %h expected %h", badaddr, 32'h1002); end
        vectors++; if (fault !== 1'b1) begin miscompares++; $display("FAIL mis_fault: got %b expected %b", fault, 1'b1); end
        vectors++; if (ras_top !== 32'h104 || ras_empty !== 1'b0) begin miscompares++; $display("FAIL mis_ras: got %h/%b expected %h/%b", ras_top, ras_empty, 32'h104, 1'b0); end
        tick();
        vectors++; if (fault !== 1'b0) begin miscompares++; $display("FAIL mis_fault_pulse: got %b expected %b", fault, 1'b0); end
    endtask

    task automatic test_exc_stall_eret();
        goto(32'h200);
        exc = 1; stall = 1;
        tick();
        idle();
        vectors++; if (pc !== EXC_VECTOR) begin miscompares++; $display("FAIL exc_pc: got %h expected %h", pc, EXC_VECTOR); end
        vectors++; if (epc !== 32'h200) begin miscompares++; $display("FAIL exc_epc: got %h expected %h", epc, 32'h200); end
        vectors++; if (fault !== 1'b0 || badaddr !== 32'h1002) begin miscompares++; $display("FAIL exc_nofault: got %b/%h expected %b/%h", fault, badaddr, 1'b0, 32'h1002); end
        tick();
        eret = 1;
        tick();
        idle();
        vectors++; if (pc !== 32'h200) begin miscompares++; $display("FAIL eret_pc: got %h expected %h", pc, 32'h200); end
    endtask

    task automatic test_pop_push();
        do_reset();
        goto(32'h100); jal();
        goto(32'h200); jal();
        goto(32'h300);
        link = 1; jr = 1; ret = 1; jr_target = 32'h204;
        tick();
        idle();
        vectors++; if (ras_hit !== 1'b1) begin miscompares++; $display("FAIL pp_hit: got %b expected %b", ras_hit, 1'b1); end
        vectors++; if (ras_top !== 32'h304) begin miscompares++; $display("FAIL pp_top: got %h expected %h", ras_top, 32'h304); end
        jr = 1; ret = 1; jr_target = 32'h304;
        tick();
        idle();
        vectors++; if (ras_top !== 32'h104 || ras_empty !== 1'b0) begin miscompares++; $display("FAIL pp_second: got %h/%b expected %h/%b", ras_top, ras_empty, 32'h104, 1'b0); end
        jr = 1; ret = 1; jr_target = 32'h104;
        tick();
        idle();
        vectors++; if (ras_empty !== 1'b1) begin miscompares++; $display("FAIL pp_count2: got %b expected %b", ras_empty, 1'b1); end
    endtask

    task automatic test_random();
        logic [31:0] r;
        logic [31:0] e_top;
        do_reset();
        for (int n = 0; n < 1500; n++) begin
            idle();
            rst    = ($urandom % 64) == 0;
            stall  = ($urandom % 8) == 0;
            exc    = ($urandom % 16) == 0;
            eret   = ($urandom % 16) == 0;
            branch = ($urandom % 4) == 0;
            jump   = ($urandom % 5) == 0;
            jr     = ($urandom % 4) == 0;
            link   = ($urandom % 3) == 0;
            ret    = ($urandom % 2) == 0;
            signimm = 32'($urandom_range(0, 64)) - 32'd32;
            r = $urandom;
            jaddr = r[25:0];
            r = $urandom;
            case ($urandom % 8)
                0:       jr_target = r;
                1, 2, 3: jr_target = (m_ras.size() > 0) ? m_ras[$] : {r[31:2], 2'b00};
                default: jr_target = {r[31:2], 2'b00};
            endcase
            tick();
            e_top = (m_ras.size() > 0) ? m_ras[$] : 32'h0;
            vectors++; if (pc !== m_pc) begin miscompares++; $display("FAIL rnd_pc@%0d: got %h expected %h", n, pc, m_pc); end
            vectors++; if (epc !== m_epc) begin miscompares++; $display("FAIL rnd_epc@%0d: got %h expected %h", n, epc, m_epc); end
            vectors++; if (badaddr !== m_bad) begin miscompares++; $display("FAIL rnd_badaddr@%0d: got %h expected %h", n, badaddr, m_bad); end
            vectors++; if (fault !== m_fault) begin miscompares++; $display("FAIL rnd_fault@%0d: got %b expected %b", n, fault, m_fault); end
            vectors++; if (ras_hit !== m_hit) begin miscompares++; $display("FAIL rnd_hit@%0d: got %b expected %b", n, ras_hit, m_hit); end
            vectors++; if (ras_top !== e_top) begin miscompares++; $display("FAIL rnd_top@%0d: got %h expected %h", n, ras_top, e_top); end
            vectors++; if (ras_empty !== (m_ras.size() == 0) || ras_full !== (m_ras.size() == DEPTH)) begin miscompares++; $display("FAIL rnd_level@%0d: got %b%b expected %b%b", n, ras_empty, ras_full, m_ras.size() == 0, m_ras.size() == DEPTH); end
            vectors++; if (pc_plus4 !== m_pc + 32'd4) begin miscompares++; $display("FAIL rnd_plus4@%0d: got %h expected %h", n, pc_plus4, m_pc + 32'd4); end
            vectors++; if (pc_branch !== m_pc + 32'd4 + (signimm << 2)) begin miscompares++; $display("FAIL rnd_branch@%0d: got %h expected %h", n, pc_branch, m_pc + 32'd4 + (signimm << 2)); end
        end
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        idle();
        m_pc = 0; m_epc = 0; m_bad = 0; m_fault = 0; m_hit = 0;
        test_reset();
        test_seq_branch();
        test_jump_stall();
        test_ras_overflow();
        test_misaligned();
        test_exc_stall_eret();
        test_pop_push();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
